// File: rtl/wb_queue_if.sv
// Bundles the two writeback producers, the register-file write port and the bypass lookups.
interface wb_queue_if;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        stall;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [4:0]  lookupAddr1;
  logic [4:0]  lookupAddr2;
  logic        hit1;
  logic        hit2;
  logic [31:0] hitData1;
  logic [31:0] hitData2;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output lookupAddr1, lookupAddr2,
    input  stall, writeEnable, writeAddr, writeData, hit1, hit2, hitData1, hitData2
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  lookupAddr1, lookupAddr2,
    output stall, writeEnable, writeAddr, writeData, hit1, hit2, hitData1, hitData2
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: merges ALU and load results into a single register-file write port,
// in acceptance order, with bypass lookup of pending writes.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    addrMem [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] memSlot;
  logic [CW-1:0] count;
  logic          stall;
  logic          aluPush;
  logic          memPush;
  logic          pop;
  logic [1:0]    numPush;
  logic          writeEnableQ;
  logic [4:0]    writeAddrQ;
  logic [31:0]   writeDataQ;
  logic          hit1;
  logic          hit2;
  logic [31:0]   hitData1;
  logic [31:0]   hitData2;
  logic [PW-1:0] idx;

  // Holding two free slots lets both producers enqueue on the same edge.
  assign stall   = count > CW'(DEPTH - 2);
  assign aluPush = !stall && bus.alu_valid && (bus.alu_addr != 5'd0);
  assign memPush = !stall && bus.mem_valid && (bus.mem_addr != 5'd0);
  assign pop     = count != '0;
  assign numPush = {1'b0, aluPush} + {1'b0, memPush};
  assign memSlot = aluPush ? tail + 1'b1 : tail;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      writeEnableQ <= 1'b0;
      writeAddrQ   <= '0;
      writeDataQ   <= '0;
    end else begin
      if (pop) begin
        writeEnableQ <= 1'b1;
        writeAddrQ   <= addrMem[head];
        writeDataQ   <= dataMem[head];
        head         <= head + 1'b1;
      end else begin
        writeEnableQ <= 1'b0;
      end
      tail  <= tail + PW'(numPush);
      count <= count + CW'(numPush) - CW'(pop);
    end
  end

  // Entry storage carries no reset; contents are invisible while count is zero.
  always_ff @(posedge clk) begin
    if (aluPush) begin
      addrMem[tail] <= bus.alu_addr;
      dataMem[tail] <= bus.alu_data;
    end
    if (memPush) begin
      addrMem[memSlot] <= bus.mem_addr;
      dataMem[memSlot] <= bus.mem_data;
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    hitData1 = '0;
    hitData2 = '0;
    idx      = '0;
    if (writeEnableQ && writeAddrQ == bus.lookupAddr1) begin
      hit1     = 1'b1;
      hitData1 = writeDataQ;
    end
    if (writeEnableQ && writeAddrQ == bus.lookupAddr2) begin
      hit2     = 1'b1;
      hitData2 = writeDataQ;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (addrMem[idx] == bus.lookupAddr1) begin
          hit1     = 1'b1;
          hitData1 = dataMem[idx];
        end
        if (addrMem[idx] == bus.lookupAddr2) begin
          hit2     = 1'b1;
          hitData2 = dataMem[idx];
        end
      end
    end
    if (bus.lookupAddr1 == 5'd0) begin
      hit1     = 1'b0;
      hitData1 = '0;
    end
    if (bus.lookupAddr2 == 5'd0) begin
      hit2     = 1'b0;
      hitData2 = '0;
    end
  end

  assign bus.stall       = stall;
  assign bus.writeEnable = writeEnableQ;
  assign bus.writeAddr   = writeAddrQ;
  assign bus.writeData   = writeDataQ;
  assign bus.hit1        = hit1;
  assign bus.hit2        = hit2;
  assign bus.hitData1    = hitData1;
  assign bus.hitData2    = hitData2;
endmodule
